sha256_arbiter: RTL

Round-robin arbiter that shares one SHA256 core (`top`: 32-bit word input, 32-bit digest output) between N requesters. It grants the core to one requester for a whole message, from its first block through its last block. It streams 16-word blocks into the core, paces blocks on core `busy`, and routes the 8 returned digest words back to the owner. It sits between the requester-side block sources and the core.

---
 rtl/sha256_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sha256_arbiter.sv
// Round-robin arbiter that shares one SHA256 core between N block sources.
// The core is held by one requester for a whole message, and its digest words are returned only to that requester.
module sha256_arbiter #(
    parameter int N   = 2,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N-1:0]      req_valid,
    input  logic [N*32-1:0]   req_data,
    input  logic [N-1:0]      req_first,
    input  logic [N-1:0]      req_last,
    output logic [N-1:0]      req_ready,
    output logic [N-1:0]      rsp_valid,
    output logic [31:0]       rsp_data,
    output logic [31:0]       core_data,
    output logic              core_write_enable,
    output logic              core_first_block,
    output logic              core_last_block,
    input  logic              core_busy,
    input  logic [31:0]       core_digest,
    input  logic              core_output_enable,
    output logic              active,
    output logic [IDW-1:0]    owner
);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT_CORE, WAIT_DIGEST} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [3:0]      word_cnt_q, word_cnt_d;
    logic [2:0]      dig_cnt_q, dig_cnt_d;
    logic            last_q, last_d;
    logic            wait_first_q, wait_first_d;

    logic [31:0]     data_w [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign data_w[gi] = req_data[32*gi +: 32];
        end
    endgenerate

    // Rotate the eligible vector so that bit 0 is the pointer position; the
    // lowest set bit is then the cyclic distance from the pointer.
    logic [2*N-1:0]  elig_rot;
    logic            found;
    logic [IDW-1:0]  win;
    int              win_sum;
    int              ptr_sum;

    always_comb begin
        elig_rot = {req_valid & req_first, req_valid & req_first} >> ptr_q;
        found    = 1'b0;
        win_sum  = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (elig_rot[k]) begin
                found   = 1'b1;
                win_sum = int'(ptr_q) + k;
            end
        end
        if (win_sum >= N) begin
            win_sum = win_sum - N;
        end
        win = IDW'(win_sum);
        ptr_sum = int'(owner_q) + 1;
        if (ptr_sum >= N) begin
            ptr_sum = 0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            word_cnt_q   <= '0;
            dig_cnt_q    <= '0;
            last_q       <= 1'b0;
            wait_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            word_cnt_q   <= word_cnt_d;
            dig_cnt_q    <= dig_cnt_d;
            last_q       <= last_d;
            wait_first_q <= wait_first_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        ptr_d             = ptr_q;
        owner_d           = owner_q;
        word_cnt_d        = word_cnt_q;
        dig_cnt_d         = dig_cnt_q;
        last_d            = last_q;
        wait_first_d      = wait_first_q;
        req_ready         = '0;
        rsp_valid         = '0;
        rsp_data          = '0;
        core_data         = '0;
        core_write_enable = 1'b0;
        core_first_block  = 1'b0;
        core_last_block   = 1'b0;
        active            = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d    = win;
                    word_cnt_d = '0;
                    dig_cnt_d  = '0;
                    state_d    = STREAM;
                end
            end
            STREAM: begin
                req_ready[owner_q] = 1'b1;
                if (req_valid[owner_q]) begin
                    core_write_enable = 1'b1;
                    core_data         = data_w[owner_q];
                    if (word_cnt_q == 4'd0) begin
                        core_first_block = req_first[owner_q];
                        core_last_block  = req_last[owner_q];
                        last_d           = req_last[owner_q];
                    end
                    word_cnt_d = word_cnt_q + 4'd1;
                    if (word_cnt_q == 4'd15) begin
                        wait_first_d = 1'b1;
                        state_d      = WAIT_CORE;
                    end
                end
            end
            WAIT_CORE: begin
                // The core may raise busy a cycle late, so the first cycle never exits.
                if (wait_first_q) begin
                    wait_first_d = 1'b0;
                end else if (!core_busy) begin
                    dig_cnt_d = '0;
                    state_d   = last_q ? WAIT_DIGEST : STREAM;
                end
            end
            WAIT_DIGEST: begin
                rsp_valid[owner_q] = core_output_enable;
                rsp_data           = core_digest;
                if (core_output_enable) begin
                    dig_cnt_d = dig_cnt_q + 3'd1;
                    if (dig_cnt_q == 3'd7) begin
                        ptr_d   = IDW'(ptr_sum);
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign owner = owner_q;

endmodule
